wb_sparse_packer: RTL and testbench
===================================

// Module: wb_sparse_packer
// PURPOSE
//  Parametrised write-back stage: reads NCH-wide psum windows from the psum buffer, applies ReLU,
//  requantises to 8 bit and emits a sparse stream (guard map + non-zero payload) to the fm/guard buffers.
//  Successor of the fixed 6-channel write-back: generic width/channels, ready/valid backpressure on
//  both outputs, masked partial last window, single-pass diff mode with packed 4-bit payload.
// PARAMETERS
//  NCH        6   channels (values) per window
//  PSUM_WIDTH 16  signed psum width
//  SHIFT      0   requant right shift applied after ReLU
//  ADDR_W     8   psum buffer address width
// PORTS
//  clk           in   1              clock
//  rst           in   1              synchronous reset, active-high
//  ctrl_valid    in   1              job request; config sampled when ctrl_valid && ctrl_ready
//  ctrl_ready    out  1              idle, can accept a job
//  ctrl_finish   out  1              one-cycle pulse, job complete
//  w_num_i       in   8              row width in values
//  h_num_i       in   8              number of rows
//  is_diff_i     in   1              0: 8-bit sparse; 1: diff mode (8-bit + packed 4-bit)
//  addr_o        out  ADDR_W         psum buffer read address
//  rd_en         out  1              read strobe; data_i valid the cycle after rd_en
//  data_i        in   NCH*PSUM_WIDTH psum window, channel 0 in LSBs
//  data_o        out  8              payload byte
//  data_o_valid  out  1              payload valid; hold data_o stable until data_o_ready
//  data_o_ready  in   1              fm buffer accepts
//  guard_o       out  2*NCH          {g4, g8}; g4 = 0 when is_diff = 0
//  guard_o_valid out  1              guard valid; held until guard_o_ready
//  guard_o_ready in   1              guard buffer accepts
// BEHAVIOUR
//  Reset (synchronous, active-high): state IDLE, ctrl_ready=1, all other outputs 0, counters/addr 0.
//  Reset mid-job aborts immediately; no finish pulse; nothing further emitted.
//  Job accept: ctrl_valid&&ctrl_ready -> latch config, ctrl_ready=0 next cycle; ctrl_valid ignored while busy.
//  Windows per row = ceil(w_num/NCH); total = h_num*that; addr_o starts at 0, +1 per window, no wrap check.
//  FSM: IDLE -> RD (rd_en=1 one cycle) -> CAP (register data_i, compute maps) -> GUARD
//   (guard_o_valid until guard_o_ready) -> EMIT (one byte per data_o handshake) -> RD of next window,
//   or DONE after last window; DONE: ctrl_finish=1 one cycle, ctrl_ready=1 next cycle, back to IDLE.
//  EMIT skipped when payload empty (GUARD -> RD/DONE directly).
//  Value per channel v = psum<0 ? 0 : min(psum>>>SHIFT, 255).
//  Partial window: channels >= remaining width in the row forced to v=0 (guard bits 0).
//  is_diff=0: g8[i] = v!=0; payload = v of set channels, ascending i.
//  is_diff=1: g8[i] = v[7:4]!=0; g4[i] = v!=0 && v[7:4]==0. Payload: g8 bytes ascending i,
//   then g4 nibbles ascending i packed two per byte, first nibble in [3:0]; odd count -> [7:4]=0.
//  Payload bytes per window <= NCH; counter width $clog2(NCH+1).
//  w_num=0 or h_num=0: no reads, no output; DONE reached 1 cycle after accept.
//  Backpressure: data_o/guard_o stable while valid&&!ready; no byte dropped or duplicated.
//  Throughput with ready tied 1: 3 + payload_bytes cycles per window.
// TESTING
//  T1 NCH=6, w=6,h=1, diff=0, psum {0,5,-3,0,300,17} -> guard g8=6'b110010, bytes 5,255,17, one finish.
//  T2 diff=1, values {0x12,0x03,0,0x04,0x50,0x07} -> g8=6'b010001, g4=6'b101010, bytes 0x12,0x50,0x43,0x07.
//  T3 w=8,h=2 -> 4 windows, addr 0..3; channels 2..5 of windows 1,3 masked to 0 regardless of psum.
//  T4 random data_o_ready/guard_o_ready stalls (50%) -> stream identical to T1/T2 golden, stable data while stalled.
//  T5 rst asserted during EMIT of window 2 -> next cycle all outputs 0, ctrl_ready=1; new job runs cleanly.
//  T6 h=0 -> ctrl_finish 1 cycle after accept, no rd_en, no valid outputs; ctrl_valid during busy ignored.

Source files
------------

// File: rtl/wb_sparse_packer.sv
// Write-back stage: reads psum windows, applies ReLU and requantisation,
// and emits a guard map plus a packed non-zero payload with ready/valid on both outputs.
module wb_sparse_packer #(
  parameter int unsigned NCH        = 6,
  parameter int unsigned PSUM_WIDTH = 16,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ctrl_valid,
  output logic                      ctrl_ready,
  output logic                      ctrl_finish,
  input  logic [7:0]                w_num_i,
  input  logic [7:0]                h_num_i,
  input  logic                      is_diff_i,
  output logic [ADDR_W-1:0]         addr_o,
  output logic                      rd_en,
  input  logic [NCH*PSUM_WIDTH-1:0] data_i,
  output logic [7:0]                data_o,
  output logic                      data_o_valid,
  input  logic                      data_o_ready,
  output logic [2*NCH-1:0]          guard_o,
  output logic                      guard_o_valid,
  input  logic                      guard_o_ready
);

  localparam int unsigned CntW = $clog2(NCH + 1);

  typedef enum logic [2:0] {StIdle, StRd, StCap, StGuard, StEmit, StDone} state_e;

  state_e          state_q;
  logic [7:0]      h_num_q, w_num_q, row_q, col_rem_q;
  logic            is_diff_q;
  logic [7:0]      pay_q [NCH];
  logic [CntW-1:0] pay_cnt_q, idx_q;

  logic [7:0]      v [NCH];
  logic [NCH-1:0]  g8_d, g4_d;
  logic [7:0]      pay_d [NCH];
  logic [CntW-1:0] pay_cnt_d;
  logic            last_win, win_done;

  // Per-channel ReLU, saturating requant, partial-window masking and guard maps.
  always_comb begin
    logic signed [PSUM_WIDTH-1:0] psum;
    logic signed [PSUM_WIDTH-1:0] shifted;
    for (int i = 0; i < int'(NCH); i++) begin
      psum    = data_i[i*PSUM_WIDTH +: PSUM_WIDTH];
      shifted = psum >>> SHIFT;
      v[i]    = 8'h00;
      // col_rem_q holds the values still left in this row; higher channels are padding
      if (i < int'(col_rem_q) && !psum[PSUM_WIDTH-1]) begin
        v[i] = (|shifted[PSUM_WIDTH-1:8]) ? 8'hff : shifted[7:0];
      end
      if (is_diff_q) begin
        g8_d[i] = |v[i][7:4];
        g4_d[i] = (v[i] != 8'h00) && ~|v[i][7:4];
      end else begin
        g8_d[i] = v[i] != 8'h00;
        g4_d[i] = 1'b0;
      end
    end
  end

  // Payload packing: full bytes first, then nibbles two per byte, low nibble first.
  always_comb begin
    logic odd;
    odd       = 1'b0;
    pay_cnt_d = '0;
    for (int i = 0; i < int'(NCH); i++) pay_d[i] = 8'h00;
    for (int i = 0; i < int'(NCH); i++) begin
      if (g8_d[i]) begin
        pay_d[pay_cnt_d] = v[i];
        pay_cnt_d        = pay_cnt_d + 1'b1;
      end
    end
    for (int i = 0; i < int'(NCH); i++) begin
      if (g4_d[i]) begin
        if (!odd) begin
          pay_d[pay_cnt_d] = {4'h0, v[i][3:0]};
          odd              = 1'b1;
        end else begin
          pay_d[pay_cnt_d][7:4] = v[i][3:0];
          pay_cnt_d             = pay_cnt_d + 1'b1;
          odd                   = 1'b0;
        end
      end
    end
    if (odd) pay_cnt_d = pay_cnt_d + 1'b1;
  end

  // Window completion: guard taken with no payload, or last payload byte taken.
  always_comb begin
    last_win = (row_q == h_num_q - 8'd1) && (col_rem_q <= 8'(NCH));
    win_done = (state_q == StGuard && guard_o_ready && pay_cnt_q == '0) ||
               (state_q == StEmit && data_o_ready && idx_q == pay_cnt_q - 1'b1);
  end

  // Main FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ctrl_ready    <= 1'b1;
      ctrl_finish   <= 1'b0;
      addr_o        <= '0;
      rd_en         <= 1'b0;
      data_o        <= 8'h00;
      data_o_valid  <= 1'b0;
      guard_o       <= '0;
      guard_o_valid <= 1'b0;
      h_num_q       <= 8'h00;
      w_num_q       <= 8'h00;
      row_q         <= 8'h00;
      col_rem_q     <= 8'h00;
      is_diff_q     <= 1'b0;
      pay_cnt_q     <= '0;
      idx_q         <= '0;
      for (int i = 0; i < int'(NCH); i++) pay_q[i] <= 8'h00;
    end else begin
      ctrl_finish <= 1'b0;
      rd_en       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ctrl_valid) begin
            ctrl_ready <= 1'b0;
            h_num_q    <= h_num_i;
            w_num_q    <= w_num_i;
            is_diff_q  <= is_diff_i;
            row_q      <= 8'h00;
            col_rem_q  <= w_num_i;
            addr_o     <= '0;
            if (w_num_i == 8'h00 || h_num_i == 8'h00) begin
              state_q     <= StDone;
              ctrl_finish <= 1'b1;
            end else begin
              state_q <= StRd;
              rd_en   <= 1'b1;
            end
          end
        end
        StRd: state_q <= StCap;
        StCap: begin
          guard_o       <= {g4_d, g8_d};
          guard_o_valid <= 1'b1;
          pay_q         <= pay_d;
          pay_cnt_q     <= pay_cnt_d;
          idx_q         <= '0;
          state_q       <= StGuard;
        end
        StGuard: begin
          if (guard_o_ready) begin
            guard_o_valid <= 1'b0;
            guard_o       <= '0;
            if (pay_cnt_q != '0) begin
              state_q      <= StEmit;
              data_o       <= pay_q[0];
              data_o_valid <= 1'b1;
            end
          end
        end
        StEmit: begin
          if (data_o_ready) begin
            if (idx_q == pay_cnt_q - 1'b1) begin
              data_o_valid <= 1'b0;
              data_o       <= 8'h00;
            end else begin
              idx_q  <= idx_q + 1'b1;
              data_o <= pay_q[idx_q + 1'b1];
            end
          end
        end
        StDone: begin
          ctrl_ready <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (win_done) begin
        if (last_win) begin
          state_q     <= StDone;
          ctrl_finish <= 1'b1;
        end else begin
          state_q <= StRd;
          rd_en   <= 1'b1;
          addr_o  <= addr_o + 1'b1;
          if (col_rem_q <= 8'(NCH)) begin
            row_q     <= row_q + 8'd1;
            col_rem_q <= w_num_q;
          end else begin
            col_rem_q <= col_rem_q - 8'(NCH);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_sparse_packer.sv
// Directed bench for wb_sparse_packer: psum memory model, stream monitor, golden streams.
module tb_wb_sparse_packer;

  localparam int NCH = 6;
  localparam int PW  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            ctrl_valid, ctrl_ready, ctrl_finish;
  logic [7:0]      w_num_i, h_num_i;
  logic            is_diff_i;
  logic [7:0]      addr_o;
  logic            rd_en;
  logic [NCH*PW-1:0] data_i = '0;
  logic [7:0]      data_o;
  logic            data_o_valid, data_o_ready;
  logic [2*NCH-1:0] guard_o;
  logic            guard_o_valid, guard_o_ready;

  wb_sparse_packer #(.NCH(NCH), .PSUM_WIDTH(PW), .SHIFT(0), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .ctrl_finish(ctrl_finish), .w_num_i(w_num_i), .h_num_i(h_num_i), .is_diff_i(is_diff_i),
    .addr_o(addr_o), .rd_en(rd_en), .data_i(data_i), .data_o(data_o),
    .data_o_valid(data_o_valid), .data_o_ready(data_o_ready), .guard_o(guard_o),
    .guard_o_valid(guard_o_valid), .guard_o_ready(guard_o_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [NCH*PW-1:0] mem [256];

  function automatic logic [NCH*PW-1:0] win(input int c0, c1, c2, c3, c4, c5);
    return {16'(c5), 16'(c4), 16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  // Stream monitor and psum buffer model
  int cyc = 0;
  always @(negedge clk) cyc++;

  logic [11:0] got_guard [$];
  logic [7:0]  got_bytes [$];
  int          got_addr  [$];
  logic [11:0] exp_g [$];
  logic [7:0]  exp_b [$];
  int          exp_a [$];
  int          fin_cnt = 0;
  int          fin_cyc = 0;
  logic        prev_dv = 1'b0, prev_dr = 1'b0, prev_gv = 1'b0, prev_gr = 1'b0, prev_rst = 1'b1;
  logic [7:0]  prev_d = '0;
  logic [11:0] prev_g = '0;
  bit          rand_rdy = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        data_i <= mem[addr_o];
        got_addr.push_back(int'(addr_o));
      end
      if (guard_o_valid && guard_o_ready) got_guard.push_back(guard_o);
      if (data_o_valid && data_o_ready) got_bytes.push_back(data_o);
      if (ctrl_finish) begin
        fin_cnt++;
        fin_cyc = cyc;
      end
      if (!prev_rst && prev_dv && !prev_dr)
        check("data_stable", {23'b0, data_o_valid, data_o}, {24'h1, prev_d});
      if (!prev_rst && prev_gv && !prev_gr)
        check("guard_stable", {19'b0, guard_o_valid, guard_o}, {20'h1, prev_g});
    end
    prev_rst = rst;
    prev_dv  = data_o_valid;
    prev_dr  = data_o_ready;
    prev_d   = data_o;
    prev_gv  = guard_o_valid;
    prev_gr  = guard_o_ready;
    prev_g   = guard_o;
  end

  always @(negedge clk) begin
    data_o_ready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    guard_o_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic clear_all();
    got_guard.delete(); got_bytes.delete(); got_addr.delete();
    exp_g.delete(); exp_b.delete(); exp_a.delete();
    fin_cnt = 0;
  endtask

  task automatic run_job(input int w, input int h, input bit diff, output int acc_cyc);
    @(negedge clk);
    w_num_i = 8'(w); h_num_i = 8'(h); is_diff_i = diff; ctrl_valid = 1'b1;
    @(posedge clk);
    acc_cyc = cyc;
    @(negedge clk);
    ctrl_valid = 1'b0;
  endtask

  task automatic wait_finish(input string tag);
    int n = 0;
    while (fin_cnt == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_finish_seen"}, 32'(fin_cnt != 0), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_nguard"}, got_guard.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < got_guard.size(); i++)
      check($sformatf("%s_guard%0d", tag, i), 32'(got_guard[i]), 32'(exp_g[i]));
    check({tag, "_nbytes"}, got_bytes.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got_bytes.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_bytes[i]), 32'(exp_b[i]));
    check({tag, "_naddr"}, got_addr.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_addr.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_a[i]);
    check({tag, "_nfinish"}, fin_cnt, 1);
  endtask

  task automatic exp_t1();
    exp_g.push_back(12'h032);
    exp_b.push_back(8'd5); exp_b.push_back(8'd255); exp_b.push_back(8'd17);
    exp_a.push_back(0);
  endtask

  task automatic exp_t2();
    exp_g.push_back(12'hA91);
    exp_b.push_back(8'h12); exp_b.push_back(8'h50); exp_b.push_back(8'h43); exp_b.push_back(8'h07);
    exp_a.push_back(0);
  endtask

  initial begin
    int acc;
    int n;
    rst = 1'b1; ctrl_valid = 1'b0; w_num_i = '0; h_num_i = '0; is_diff_i = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl_ready", 32'(ctrl_ready), 32'd1);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_data_valid", 32'(data_o_valid), 32'd0);
    check("rst_guard_valid", 32'(guard_o_valid), 32'd0);
    check("rst_finish", 32'(ctrl_finish), 32'd0);
    check("rst_addr", 32'(addr_o), 32'd0);
    rst = 1'b0;

    // T1: plain sparse window, ready tied high, latency 3 + 3 bytes
    clear_all(); exp_t1();
    mem[0] = win(0, 5, -3, 0, 300, 17);
    run_job(6, 1, 1'b0, acc);
    wait_finish("t1");
    cmp_stream("t1");
    check("t1_latency", 32'(fin_cyc - acc), 32'd7);

    // T2: diff mode with packed nibbles
    clear_all(); exp_t2();
    mem[0] = win('h12, 'h03, 0, 'h04, 'h50, 'h07);
    run_job(6, 1, 1'b1, acc);
    wait_finish("t2");
    cmp_stream("t2");

    // T3: two rows of width 8 with masked partial windows; busy ctrl_valid ignored
    clear_all();
    mem[0] = win(1, 2, 3, 4, 5, 6);
    mem[1] = win(7, 7, 7, 7, 7, 7);
    mem[2] = win(0, 0, 0, 0, 0, 9);
    mem[3] = win(-1, 0, 100, 100, 100, 100);
    exp_g.push_back(12'h03F); exp_g.push_back(12'h003);
    exp_g.push_back(12'h020); exp_g.push_back(12'h000);
    for (int i = 1; i <= 6; i++) exp_b.push_back(8'(i));
    exp_b.push_back(8'd7); exp_b.push_back(8'd7); exp_b.push_back(8'd9);
    for (int i = 0; i < 4; i++) exp_a.push_back(i);
    run_job(8, 2, 1'b0, acc);
    w_num_i = 8'd6; h_num_i = 8'd5; ctrl_valid = 1'b1;
    repeat (2) @(negedge clk);
    ctrl_valid = 1'b0;
    wait_finish("t3");
    repeat (10) @(negedge clk);
    cmp_stream("t3");

    // T4: random stalls on both outputs, same golden streams
    rand_rdy = 1'b1;
    clear_all(); exp_t1();
    mem[0] = win(0, 5, -3, 0, 300, 17);
    run_job(6, 1, 1'b0, acc);
    wait_finish("t4a");
    cmp_stream("t4a");
    clear_all(); exp_t2();
    mem[0] = win('h12, 'h03, 0, 'h04, 'h50, 'h07);
    run_job(6, 1, 1'b1, acc);
    wait_finish("t4b");
    cmp_stream("t4b");
    rand_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // T5: reset while emitting window 2 aborts the job
    clear_all();
    for (int i = 0; i < 3; i++) mem[i] = win(0, 5, -3, 0, 300, 17);
    run_job(18, 1, 1'b0, acc);
    n = 0;
    while (!(addr_o == 8'd2 && data_o_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t5_reach_emit", 32'(n < 500), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_ctrl_ready", 32'(ctrl_ready), 32'd1);
    check("t5_rd_en", 32'(rd_en), 32'd0);
    check("t5_data_valid", 32'(data_o_valid), 32'd0);
    check("t5_data", 32'(data_o), 32'd0);
    check("t5_guard_valid", 32'(guard_o_valid), 32'd0);
    check("t5_guard", 32'(guard_o), 32'd0);
    check("t5_addr", 32'(addr_o), 32'd0);
    check("t5_finish", 32'(ctrl_finish), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("t5_no_finish", fin_cnt, 0);
    clear_all(); exp_t1();
    run_job(6, 1, 1'b0, acc);
    wait_finish("t5_after");
    cmp_stream("t5_after");

    // T6: empty jobs finish one cycle after accept, no traffic
    clear_all();
    @(negedge clk);
    w_num_i = 8'd6; h_num_i = 8'd0; is_diff_i = 1'b0; ctrl_valid = 1'b1;
    @(posedge clk);
    acc = cyc;
    @(negedge clk);
    h_num_i = 8'd3;
    @(negedge clk);
    ctrl_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("t6_nfinish", fin_cnt, 1);
    check("t6_latency", 32'(fin_cyc - acc), 32'd1);
    check("t6_nrd", got_addr.size(), 0);
    check("t6_nguard", got_guard.size(), 0);
    check("t6_nbytes", got_bytes.size(), 0);
    clear_all();
    run_job(0, 3, 1'b0, acc);
    wait_finish("t6w");
    check("t6w_nfinish", fin_cnt, 1);
    check("t6w_latency", 32'(fin_cyc - acc), 32'd1);
    check("t6w_nrd", got_addr.size(), 0);
    check("t6w_nguard", got_guard.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
